// File: rtl/debounce_pkg.sv
// Shared constants, width helpers and hold-phase encoding for the multi-channel debouncer.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 50;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  typedef enum logic {
    HOLD_WAIT,
    HOLD_REPEAT
  } hold_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchroniser, stability counter, edge pulses and hold/repeat timing.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = 0,
  parameter int unsigned REPEAT_CYCLES = 0,
  parameter int unsigned ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CW = count_width(STABLE_CYCLES);
  localparam int unsigned HW = count_width(max3(HOLD_CYCLES, REPEAT_CYCLES, 1));
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic INVERT = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   cand, cand_n;
  logic [CW-1:0]          cnt, cnt_n;
  hold_state_t            hstate, hstate_n;
  logic [HW-1:0]          hcnt, hcnt_n;
  logic                   level_n, press_n, release_n, hold_n, repeat_n;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync          <= '0;
      cand          <= 1'b0;
      cnt           <= '0;
      hstate        <= HOLD_WAIT;
      hcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], btn_in ^ INVERT};
      cand          <= cand_n;
      cnt           <= cnt_n;
      hstate        <= hstate_n;
      hcnt          <= hcnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      hold_pulse    <= hold_n;
      repeat_pulse  <= repeat_n;
    end
  end

  always_comb begin
    cand_n    = cand;
    cnt_n     = cnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    hstate_n  = hstate;
    hcnt_n    = hcnt;
    hold_n    = 1'b0;
    repeat_n  = 1'b0;

    if (s != cand) begin
      cand_n = s;
      cnt_n  = '0;
    end else if (cnt < STABLE_MAX) begin
      cnt_n = cnt + 1'b1;
    end else if (btn_level != cand) begin
      level_n   = cand;
      press_n   = cand;
      release_n = ~cand;
    end

    // Hold timing keys off the next level so a release suppresses any pulse on its own edge;
    // counting starts the edge after the press so hold lands HOLD_CYCLES edges later.
    if (HOLD_CYCLES == 0 || !level_n) begin
      hstate_n = HOLD_WAIT;
      hcnt_n   = '0;
    end else if (!btn_level) begin
      hcnt_n = '0;
    end else if (hstate == HOLD_WAIT) begin
      if (hcnt == HOLD_LAST) begin
        hold_n   = 1'b1;
        hstate_n = HOLD_REPEAT;
        hcnt_n   = '0;
      end else begin
        hcnt_n = hcnt + 1'b1;
      end
    end else if (REPEAT_CYCLES != 0) begin
      if (hcnt == REPEAT_LAST) begin
        repeat_n = 1'b1;
        hcnt_n   = '0;
      end else begin
        hcnt_n = hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: NUM_CH independent channels side by side.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = 0,
  parameter int unsigned REPEAT_CYCLES = 0,
  parameter int unsigned ACTIVE_LOW    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] hold_pulse,
  output logic [NUM_CH-1:0] repeat_pulse
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .btn_in       (btn_in[g]),
      .btn_level    (btn_level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .hold_pulse   (hold_pulse[g]),
      .repeat_pulse (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: expected pulse events are queued when stimulus is driven.
module tb_debounce_multi;

  localparam int unsigned NCH  = 4;
  localparam int unsigned LAT  = 7;   // 2 sync stages + 4 stable cycles + 1
  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 5;

  localparam int unsigned K_PRESS = 0, K_REL = 1, K_HOLD = 2, K_REP = 3;

  typedef struct {
    int unsigned cyc;
    int unsigned inst;
    int unsigned ch;
    int unsigned kind;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0] btn_m, lvl_m, prs_m, rel_m, hld_m, rpt_m;
  logic [NCH-1:0] btn_a, lvl_a, prs_a, rel_a, hld_a, rpt_a;

  ev_t sb[$];
  logic [NCH-1:0] exp_lvl[2];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .NUM_CH(NCH), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)
  ) u_main (
    .clk(clk), .reset(reset), .btn_in(btn_m), .btn_level(lvl_m),
    .press_pulse(prs_m), .release_pulse(rel_m), .hold_pulse(hld_m), .repeat_pulse(rpt_m)
  );

  debounce_multi #(
    .NUM_CH(NCH), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)
  ) u_alt (
    .clk(clk), .reset(reset), .btn_in(btn_a), .btn_level(lvl_a),
    .press_pulse(prs_a), .release_pulse(rel_a), .hold_pulse(hld_a), .repeat_pulse(rpt_a)
  );

  task automatic chk(input string tag, input int unsigned inst, input logic [NCH-1:0] obs,
                     input logic [NCH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%b expected=%b", tag, inst, cyc, obs, exp);
    end
  endtask

  // Accepted rise first sampled at t_rise (and fall at t_fall when has_fall): queue expected pulses.
  task automatic sched(input int unsigned inst, input int unsigned ch, input int unsigned t_rise,
                       input int unsigned t_fall, input bit has_fall);
    int unsigned tp, tr, th;
    tp = t_rise + LAT;
    tr = t_fall + LAT;
    th = tp + HOLD;
    sb.push_back('{tp, inst, ch, K_PRESS});
    if (has_fall) sb.push_back('{tr, inst, ch, K_REL});
    if (!has_fall || th < tr) sb.push_back('{th, inst, ch, K_HOLD});
    if (has_fall)
      for (int unsigned t = th + REP; t < tr; t += REP) sb.push_back('{t, inst, ch, K_REP});
  endtask

  task automatic check();
    logic [NCH-1:0] ep[2], er[2], eh[2], eq[2];
    for (int unsigned n = 0; n < 2; n++) begin
      ep[n] = '0; er[n] = '0; eh[n] = '0; eq[n] = '0;
    end
    if (reset) begin
      exp_lvl[0] = '0;
      exp_lvl[1] = '0;
      sb.delete();
    end else begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            K_PRESS: ep[sb[i].inst][sb[i].ch] = 1'b1;
            K_REL:   er[sb[i].inst][sb[i].ch] = 1'b1;
            K_HOLD:  eh[sb[i].inst][sb[i].ch] = 1'b1;
            default: eq[sb[i].inst][sb[i].ch] = 1'b1;
          endcase
          sb.delete(i);
        end
      end
      for (int unsigned n = 0; n < 2; n++) exp_lvl[n] = (exp_lvl[n] | ep[n]) & ~er[n];
    end
    chk("level",   0, lvl_m, exp_lvl[0]);
    chk("press",   0, prs_m, ep[0]);
    chk("release", 0, rel_m, er[0]);
    chk("hold",    0, hld_m, eh[0]);
    chk("repeat",  0, rpt_m, eq[0]);
    chk("level",   1, lvl_a, exp_lvl[1]);
    chk("press",   1, prs_a, ep[1]);
    chk("release", 1, rel_a, er[1]);
    chk("hold",    1, hld_a, eh[1]);
    chk("repeat",  1, rpt_a, eq[1]);
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check();
    end
  endtask

  initial begin
    int unsigned t0, t1;
    exp_lvl[0] = '0;
    exp_lvl[1] = '0;
    reset = 1'b1;
    btn_m = '0;
    btn_a = '1;
    step(3);
    reset = 1'b0;
    step(3);

    // Clean press on ch0, held long enough for hold but released before the first repeat.
    t0 = cyc + 1;
    btn_m[0] = 1'b1;
    sched(0, 0, t0, t0 + 12, 1'b1);
    step(12);
    btn_m[0] = 1'b0;
    step(14);

    // Glitch widths on ch2: 5 sample edges rejected, 6 accepted.
    btn_m[2] = 1'b1;
    step(5);
    btn_m[2] = 1'b0;
    step(15);
    t0 = cyc + 1;
    btn_m[2] = 1'b1;
    sched(0, 2, t0, t0 + 6, 1'b1);
    step(6);
    btn_m[2] = 1'b0;
    step(15);

    // Bounce on ch1: toggles every 3 cycles for 30 cycles, then settles high.
    for (int unsigned i = 0; i < 10; i++) begin
      btn_m[1] = (i % 2 == 0);
      step(3);
    end
    t0 = cyc + 1;
    btn_m[1] = 1'b1;
    sched(0, 1, t0, t0 + 20, 1'b1);
    step(20);
    btn_m[1] = 1'b0;
    step(12);

    // Hold and repeats on ch3; the repeat that coincides with release must not appear.
    t0 = cyc + 1;
    btn_m[3] = 1'b1;
    sched(0, 3, t0, t0 + 40, 1'b1);
    step(40);
    btn_m[3] = 1'b0;
    step(12);

    // Active-low instance: pins idle high through reset, then pin 0 pressed.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    t0 = cyc + 1;
    btn_a[0] = 1'b0;
    sched(1, 0, t0, t0 + 9, 1'b1);
    step(9);
    btn_a[0] = 1'b1;
    step(12);

    // Reset while ch0 is pressed and counting toward hold; the press re-qualifies afterwards.
    t0 = cyc + 1;
    btn_m[0] = 1'b1;
    sched(0, 0, t0, 0, 1'b0);
    step(11);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    t1 = cyc + 1;
    sched(0, 0, t1, t1 + 30, 1'b1);
    step(30);
    btn_m[0] = 1'b0;
    step(12);

    chk("pending", 0, NCH'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
